// File: rtl/max_pkg.sv
// Shared definitions for the loader and the 4-number max stage.
package max_pkg;

    localparam int unsigned OPW  = 4;
    localparam int unsigned NUMS = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } loader_state_t;

endpackage

// File: rtl/load_counter.sv
// Saturating 0..N up-counter with synchronous clear and asynchronous reset.
module load_counter #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          full
);

    assign full = (count == CW'(N));

    // Clear has priority over increment; the count holds once it reaches N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !full) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/max_operand_loader.sv
// Serial-to-parallel operand loader feeding the 4-number max stage.
// Operands arrive one per handshake and fill nums[1..N] in arrival order.
module max_operand_loader
    import max_pkg::*;
#(
    parameter int unsigned W  = OPW,
    parameter int unsigned N  = NUMS,
    localparam int unsigned CW = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    output logic                 in_ready,
    output logic [1:N][W-1:0]    nums,
    output logic                 nums_valid,
    input  logic                 ack,
    output logic [CW-1:0]        count
);

    loader_state_t state;
    loader_state_t state_next;

    logic accept;
    logic clr;
    logic inc;
    logic full;

    load_counter #(
        .N  (N),
        .CW (CW)
    ) u_load_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc),
        .count (count),
        .full  (full)
    );

    // Moore outputs decoded from state only.
    assign in_ready   = (state == LOAD);
    assign nums_valid = (state == FULL);
    assign accept     = in_ready && in_valid;

    // Next-state logic; start in LOAD wins over a simultaneous accept.
    always_comb begin
        state_next = state;
        clr        = 1'b0;
        inc        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (start) begin
                    clr = 1'b1;
                end else if (accept && !full) begin
                    inc = 1'b1;
                    if (count == CW'(N - 1)) begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand register file: an accepted operand lands at index count+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nums <= '0;
        end else if (clr) begin
            nums <= '0;
        end else if (inc) begin
            for (int i = 1; i <= int'(N); i++) begin
                if (count == CW'(i - 1)) begin
                    nums[i] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_max_operand_loader.sv
// Directed self-checking bench for max_operand_loader.
module tb_max_operand_loader;

    logic            clk;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [3:0]      in_data;
    logic            in_ready;
    logic [1:4][3:0] nums;
    logic            nums_valid;
    logic            ack;
    logic [2:0]      count;

    int checks;
    int errors;

    max_operand_loader #(
        .W (4),
        .N (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .nums       (nums),
        .nums_valid (nums_valid),
        .ack        (ack),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic feed(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    // Behaviour of the chained max stage, applied to the delivered set.
    function automatic logic [7:0] max_of(input logic [1:4][3:0] v);
        logic [7:0] m;
        m = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            if ({4'h0, v[i]} > m) m = {4'h0, v[i]};
        end
        return m;
    endfunction

    logic [3:0] vec1 [4];
    int         rdy_cycles;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        ack      = 1'b0;
        step();
        step();

        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_nums_valid", 32'(nums_valid), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_nums", 32'(nums), 32'h0);
        rst = 1'b0;
        step();

        // 1: contiguous set 3,9,5,C
        vec1[0] = 4'h3; vec1[1] = 4'h9; vec1[2] = 4'h5; vec1[3] = 4'hC;
        pulse_start();
        rdy_cycles = 0;
        in_valid   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = vec1[k];
            if (in_ready) rdy_cycles++;
            step();
        end
        in_valid = 1'b0;
        check("t1_ready_cycles", 32'(rdy_cycles), 32'd4);
        check("t1_ready_low_after", 32'(in_ready), 32'd0);
        check("t1_nums", 32'(nums), 32'h395C);
        check("t1_nums_valid", 32'(nums_valid), 32'd1);
        check("t1_count", 32'(count), 32'd4);
        check("t1_max", 32'(max_of(nums)), 32'h0C);
        pulse_ack();
        check("t1_valid_drop", 32'(nums_valid), 32'd0);

        // 2: in_valid alternating, only valid beats captured
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = (k % 2 == 0) ? 4'(k / 2 + 1) : 4'hE;
            step();
        end
        in_valid = 1'b0;
        check("t2_nums", 32'(nums), 32'h1234);
        check("t2_nums_valid", 32'(nums_valid), 32'd1);

        // 3: held in FULL under in_valid and start pulses
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 4'hF;
            start    = (k % 3 == 0);
            step();
            check("t3_ready_low", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("t3_nums_hold", 32'(nums), 32'h1234);
        check("t3_count_hold", 32'(count), 32'd4);
        check("t3_valid_hold", 32'(nums_valid), 32'd1);
        pulse_ack();
        check("t3_valid_drop", 32'(nums_valid), 32'd0);
        check("t3_idle_ready", 32'(in_ready), 32'd0);
        check("t3_nums_kept", 32'(nums), 32'h1234);

        // 4: restart mid-load; colliding operand A is discarded
        pulse_start();
        feed(4'h7);
        feed(4'h8);
        check("t4_count_two", 32'(count), 32'd2);
        check("t4_nums_partial", 32'(nums), 32'h7800);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'hA;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        check("t4_count_clr", 32'(count), 32'd0);
        check("t4_nums_clr", 32'(nums), 32'h0);
        check("t4_still_load", 32'(in_ready), 32'd1);
        feed(4'hB);
        feed(4'hC);
        feed(4'hD);
        check("t4_not_full_yet", 32'(nums_valid), 32'd0);
        feed(4'hE);
        check("t4_fresh_nums", 32'(nums), 32'hBCDE);
        check("t4_fresh_valid", 32'(nums_valid), 32'd1);
        pulse_ack();

        // 5: asynchronous reset after 3 accepts
        pulse_start();
        feed(4'h1);
        feed(4'h2);
        feed(4'h3);
        check("t5_count_three", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_nums", 32'(nums), 32'h0);
        check("t5_rst_ready", 32'(in_ready), 32'd0);
        check("t5_rst_valid", 32'(nums_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 4'h4;
            step();
            check("t5_never_valid", 32'(nums_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("t5_count_zero", 32'(count), 32'd0);

        // 6: all-equal and all-max sets, then ack+start together
        pulse_start();
        for (int k = 0; k < 4; k++) feed(4'h0);
        check("t6_zero_valid", 32'(nums_valid), 32'd1);
        check("t6_zero_nums", 32'(nums), 32'h0000);
        check("t6_zero_max", 32'(max_of(nums)), 32'h00);
        pulse_ack();
        pulse_start();
        for (int k = 0; k < 4; k++) feed(4'hF);
        check("t6_max_valid", 32'(nums_valid), 32'd1);
        check("t6_max_nums", 32'(nums), 32'hFFFF);
        check("t6_max_max", 32'(max_of(nums)), 32'h0F);
        ack   = 1'b1;
        start = 1'b1;
        step();
        ack   = 1'b0;
        start = 1'b0;
        check("t6_ackstart_valid", 32'(nums_valid), 32'd0);
        check("t6_ackstart_idle", 32'(in_ready), 32'd0);
        step();
        check("t6_still_idle", 32'(in_ready), 32'd0);
        pulse_start();
        check("t6_new_load", 32'(in_ready), 32'd1);
        check("t6_new_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
